uc0_issue: RTL and testbench

Stage-2 issue register with hazard detection, directly upstream of the stage-3 control register. It latches the 27-bit microinstruction word from fetch, presents its ALU/SH/M/B/C/T fields to stage 3, and raises HOLD when the held instruction's source register is still being produced downstream. While HOLD is high, stage 3 loads its NOP and this block freezes its own contents. It also tells fetch to stall, and keeps stall statistics.

---
 rtl/uc0_issue.sv | 115 +++++++++++
 tb/tb_uc0_issue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uc0_issue.sv
// Stage-2 issue register: holds one microinstruction for stage 3 and raises HOLD on a source hazard.
// Optional macro FWD_EN: forwarding present, only a stage-3 load-use stalls.
//
// state     | meaning
// S_EMPTY   | V2=0, fields hold the NOP word
// S_RUN     | V2=1, instruction loaded on the last edge
// S_HOLDING | V2=1, last edge was a HOLD edge, contents frozen
module uc0_issue #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic             CLK2,
    input  logic             RST,
    input  logic [26:0]      IW,
    input  logic             IW_VALID,
    input  logic [5:0]       C3,
    input  logic [1:0]       M3,
    input  logic [5:0]       C4,
    output logic [3:0]       ALU_out,
    output logic [1:0]       SH_out,
    output logic [1:0]       M2,
    output logic [5:0]       B2,
    output logic [5:0]       C2,
    output logic [6:0]       T2,
    output logic             HOLD,
    output logic             STALL,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic             ERR
);

    localparam logic [26:0] NOP_W = {7'd0, 6'b100011, 6'b000000, 2'b00, 2'b00, 4'b1111};
    localparam int RW = $clog2(MAX_HOLD + 2);
    localparam logic [RW-1:0] MAX_HOLD_C = RW'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_RUN     = 2'd1,
        S_HOLDING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [26:0]      iw_q, iw_d;
    logic [RW-1:0]    run_q, run_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;
    logic             v2;
    logic             match3, match4, hazard;

    assign {T2, C2, B2, M2, SH_out, ALU_out} = iw_q;

    assign v2     = (state_q != S_EMPTY);
    assign match3 = B2[5] & ~C3[5] & (B2[4:0] == C3[4:0]);
    assign match4 = B2[5] & ~C4[5] & (B2[4:0] == C4[4:0]);

`ifdef FWD_EN
    logic unused_fwd;
    assign unused_fwd = match4;
    assign hazard     = match3 & (M3 == 2'b01);
`else
    logic unused_m3;
    assign unused_m3 = ^M3;
    assign hazard    = match3 | match4;
`endif

    assign HOLD      = v2 & hazard;
    assign STALL     = HOLD;
    assign STALL_CNT = stall_cnt_q;
    assign ERR       = err_q;

    always_comb begin
        state_d     = state_q;
        iw_d        = iw_q;
        run_d       = run_q;
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        if (HOLD) begin
            state_d = S_HOLDING;
            // run counter parks at MAX_HOLD; one more hold edge means the limit is exceeded
            if (run_q != MAX_HOLD_C) begin
                run_d = run_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end else begin
            run_d = '0;
            if (IW_VALID) begin
                iw_d    = IW;
                state_d = S_RUN;
            end else begin
                iw_d    = NOP_W;
                state_d = S_EMPTY;
            end
        end
    end

    always_ff @(posedge CLK2) begin
        if (RST) begin
            state_q     <= S_EMPTY;
            iw_q        <= NOP_W;
            run_q       <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            iw_q        <= iw_d;
            run_q       <= run_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_uc0_issue.sv
// Bench for uc0_issue: per-cycle vector table through a scoreboard queue, plus a STALL_CNT saturation run.
module tb_uc0_issue;

    logic        CLK2 = 1'b0;
    logic        RST = 1'b1;
    logic [26:0] IW = '0;
    logic        IW_VALID = 1'b0;
    logic [5:0]  C3 = 6'b100011;
    logic [1:0]  M3 = 2'b00;
    logic [5:0]  C4 = 6'b100011;
    logic [3:0]  ALU_out;
    logic [1:0]  SH_out, M2;
    logic [5:0]  B2, C2;
    logic [6:0]  T2;
    logic        HOLD, STALL, ERR;
    logic [7:0]  STALL_CNT;

    int checks = 0;
    int failures = 0;

    uc0_issue #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .CLK2(CLK2), .RST(RST), .IW(IW), .IW_VALID(IW_VALID),
        .C3(C3), .M3(M3), .C4(C4),
        .ALU_out(ALU_out), .SH_out(SH_out), .M2(M2), .B2(B2), .C2(C2), .T2(T2),
        .HOLD(HOLD), .STALL(STALL), .STALL_CNT(STALL_CNT), .ERR(ERR)
    );

    always #5 CLK2 = ~CLK2;

    typedef struct {
        logic        rst;
        logic        iwv;
        logic [26:0] iw;
        logic [5:0]  c3;
        logic [1:0]  m3;
        logic [5:0]  c4;
        logic        chk;
        logic [26:0] exp_w;
        logic        exp_hold;
        logic [7:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t tab[$];
    vec_t sb[$];

    localparam logic [5:0] NC = 6'b100011;
    localparam logic [5:0] W5 = 6'b000101;
    localparam logic [5:0] W7 = 6'b000111;
    localparam logic [5:0] X5 = 6'b100101;

    function automatic logic [26:0] mk(input logic [6:0] t, input logic [5:0] c, input logic [5:0] b,
                                       input logic [1:0] m, input logic [1:0] sh, input logic [3:0] alu);
        return {t, c, b, m, sh, alu};
    endfunction

    logic [26:0] NOPW, I1, I2, I3, I4;

    task automatic add(input logic rst, input logic iwv, input logic [26:0] iw,
                       input logic [5:0] c3, input logic [1:0] m3, input logic [5:0] c4,
                       input logic chk, input logic [26:0] w, input logic h, input int cnt, input logic err);
        vec_t v;
        v.rst = rst; v.iwv = iwv; v.iw = iw; v.c3 = c3; v.m3 = m3; v.c4 = c4;
        v.chk = chk; v.exp_w = w; v.exp_hold = h; v.exp_cnt = 8'(cnt); v.exp_err = err;
        tab.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [26:0] dut_w();
        return {T2, C2, B2, M2, SH_out, ALU_out};
    endfunction

    initial begin
        int base;
        vec_t v, e;
        NOPW = mk(7'd0, NC, 6'b000000, 2'b00, 2'b00, 4'b1111);
        I1   = mk(7'h11, W7, X5, 2'b00, 2'b01, 4'b0010);          // reads r5, writes r7
        I2   = mk(7'h22, 6'b001000, X5, 2'b01, 2'b10, 4'b0101);   // reads r5
        I3   = mk(7'h33, 6'b100001, W5, 2'b00, 2'b11, 4'b1001);   // B[5]=0: no read
        I4   = mk(7'h44, 6'b000010, 6'b100111, 2'b00, 2'b00, 4'b0011); // reads r7

        // reset for two edges with IW_VALID high, then independent stream
        add(1, 1, I1, NC, 2'b00, NC, 0, NOPW, 0, 0, 0);
        add(1, 1, I1, NC, 2'b00, NC, 1, NOPW, 0, 0, 0);
        add(0, 1, I1, NC, 2'b00, NC, 1, NOPW, 0, 0, 0);
        add(0, 1, I3, W7, 2'b00, X5, 1, I1,   0, 0, 0);
        add(0, 1, I2, W5, 2'b00, NC, 1, I3,   0, 0, 0);
`ifdef FWD_EN
        add(0, 1, I4, W5, 2'b01, NC, 1, I2, 1, 0, 0);
        add(0, 1, I4, NC, 2'b00, W5, 1, I2, 0, 1, 0);
        add(0, 1, I2, W7, 2'b00, NC, 1, I4, 0, 1, 0);
        for (int k = 0; k < 6; k++) add(0, 1, I4, W5, 2'b01, NC, 1, I2, 1, 1 + k, (k == 5));
        add(0, 1, I4, NC, 2'b00, NC, 1, I2, 0, 7, 1);
        base = 7;
`else
        add(0, 1, I4, W5, 2'b00, NC, 1, I2,   1, 0, 0);
        add(0, 1, I4, NC, 2'b00, W5, 1, I2,   1, 1, 0);
        add(0, 1, I4, NC, 2'b00, NC, 1, I2,   0, 2, 0);
        add(0, 0, I1, NC, 2'b00, NC, 1, I4,   0, 2, 0);
        add(0, 1, I1, NC, 2'b00, NC, 1, NOPW, 0, 2, 0);
        add(0, 1, I2, X5, 2'b00, X5, 1, I1,   0, 2, 0);
        add(0, 1, I4, NC, 2'b00, W5, 1, I2,   1, 2, 0);
        for (int k = 0; k < 5; k++) add(0, 1, I4, W5, 2'b01, NC, 1, I2, 1, 3 + k, (k == 4));
        add(0, 1, I4, NC, 2'b00, NC, 1, I2,   0, 8, 1);
        base = 8;
`endif
        // mid-hold reset, then replay
        add(0, 1, I1, W7, 2'b01, NC, 1, I4,   1, base, 1);
        add(1, 1, I1, W7, 2'b01, NC, 1, I4,   1, base + 1, 1);
        add(0, 0, I1, W7, 2'b01, NC, 1, NOPW, 0, 0, 0);
        add(0, 1, I4, W7, 2'b01, NC, 1, NOPW, 0, 0, 0);
        add(0, 1, I4, NC, 2'b00, NC, 1, I4,   0, 0, 0);

        foreach (tab[i]) begin
            v = tab[i];
            RST = v.rst; IW_VALID = v.iwv; IW = v.iw; C3 = v.c3; M3 = v.m3; C4 = v.c4;
            sb.push_back(v);
            @(negedge CLK2);
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard: empty queue at row %0d", i);
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    check($sformatf("row%0d fields", i), 32'(dut_w()), 32'(e.exp_w));
                    check($sformatf("row%0d hold", i), 32'(HOLD), 32'(e.exp_hold));
                    check($sformatf("row%0d stall", i), 32'(STALL), 32'(e.exp_hold));
                    check($sformatf("row%0d stall_cnt", i), 32'(STALL_CNT), 32'(e.exp_cnt));
                    check($sformatf("row%0d err", i), 32'(ERR), 32'(e.exp_err));
                end
            end
            @(posedge CLK2);
            #1;
        end

        // I4 is held; keep its producer in stage 3 long enough to saturate STALL_CNT
        RST = 0; IW_VALID = 1; IW = I1; C3 = W7; M3 = 2'b01; C4 = NC;
        repeat (260) @(posedge CLK2);
        @(negedge CLK2);
        check("sat stall_cnt", 32'(STALL_CNT), 32'd255);
        check("sat hold", 32'(HOLD), 32'd1);
        check("sat fields frozen", 32'(dut_w()), 32'(I4));
        check("sat err", 32'(ERR), 32'd1);
        C3 = NC; M3 = 2'b00;
        @(negedge CLK2);
        check("release hold", 32'(HOLD), 32'd0);
        @(negedge CLK2);
        check("release fields", 32'(dut_w()), 32'(I1));
        check("release stall_cnt", 32'(STALL_CNT), 32'd255);
        check("release err sticky", 32'(ERR), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
